// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: FSM state, fetch buffer entry, widths.
package fetch_pkg;
  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; head is read from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic           do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns fetch_pc and the FETCH/FAULT FSM, feeds the fetch FIFO toward decode.
// Optional FETCH_BOUNDS_CHECK_EN: fault when fetch_pc runs past the end of instruction memory.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  logic [PC_W-1:0] fetch_pc;
  logic            full, empty, push, pop, oob, misaligned;
  logic [CW-1:0]   count;
  fetch_entry_t    head, push_entry;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign oob     = fetch_pc > PC_W'(IMEM_BYTES - INSTR_BYTES);
  assign imem_pc = fetch_pc;
`else
  // Memory address wraps; the unmasked PC still travels with the instruction.
  assign oob     = 1'b0;
  assign imem_pc = fetch_pc & PC_W'(IMEM_BYTES - 1);
`endif

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign pop        = !empty && out_ready && !redirect_valid;
  assign push       = !redirect_valid && (state == FETCH) && !oob && (!full || pop);
  assign push_entry = '{pc: fetch_pc, instr: imem_instr};

  assign out_valid  = (count != '0);
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      if (misaligned) begin
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        state    <= FETCH;
        fault    <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (oob) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= fetch_pc;
          end else if (push) begin
            fetch_pc <= fetch_pc + PC_W'(INSTR_BYTES);
          end
        end
        FAULT: ;
        default: state <= FETCH;
      endcase
    end
  end
endmodule
